// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly after the I-cache.
// Owns the PC, keeps a single read outstanding, and queues the returned words
// in a small FIFO that feeds decode over a valid/ready handshake. A branch
// redirect flushes the queue and restarts fetch at the new target.
// Optional build macro: FETCH_PERF_EN adds the perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              drop;

    logic [INST_W-1:0] q_data [FQ_DEPTH];
    logic [ADDR_W-1:0] q_pc   [FQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic slot_free;
    logic accept;
    logic push;
    logic pop;
    logic drop_set;

    // Handshake decode: one outstanding request, its queue slot reserved at issue.
    assign slot_free = (count < CNT_W'(FQ_DEPTH));
    assign req_valid = !rst && (state == S_ISSUE) && slot_free;
    assign req_addr  = pc;
    assign accept    = req_valid && req_ready;
    assign inst_valid = (count != '0);
    // A redirect flushes the queue, so a same-cycle pop or push is meaningless.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state == S_WAIT) && resp_valid && !drop && !redirect_valid;
    // A request that is (or just became) outstanding when the redirect hits must
    // have its response swallowed, so the FSM keeps waiting with drop set.
    assign drop_set = redirect_valid &&
                      (((state == S_WAIT) && !resp_valid) || accept);

    // NOTE: queue storage is not reset; masking the head with inst_valid keeps
    // inst_data/inst_pc at zero whenever nothing is queued.
    assign inst_data = inst_valid ? q_data[rd_ptr] : '0;
    assign inst_pc   = inst_valid ? q_pc[rd_ptr]   : '0;

    // Next-state logic; redirect overrides every normal transition.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            S_ISSUE: begin
                if (accept)          state_nxt = S_WAIT;
                else if (!slot_free) state_nxt = S_FULL;
            end
            S_WAIT: begin
                if (resp_valid) state_nxt = S_ISSUE;
            end
            S_FULL: begin
                if (pop || slot_free) state_nxt = S_ISSUE;
            end
            default: state_nxt = S_ISSUE;
        endcase
        if (redirect_valid) begin
            state_nxt = drop_set ? S_WAIT : S_ISSUE;
        end
    end

    // FSM, PC and drop-flag registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= S_ISSUE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc & ~ADDR_W'(3);
            end else if (accept) begin
                pc <= pc + ADDR_W'(4);
            end
            if (drop_set) begin
                drop <= 1'b1;
            end else if ((state == S_WAIT) && resp_valid) begin
                drop <= 1'b0;
            end
        end
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= resp_data;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: words enqueued and cycles spent not issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if ((state == S_WAIT) || (state == S_FULL)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A tiny cache model answers each accepted request after a programmable
// latency with data = addr ^ 0xA5A5A5A5. Inputs change on the falling edge,
// outputs are sampled there too, well away from the rising edge.
// Perf counter checks are active when FETCH_PERF_EN is defined.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    // Cache model state.
    int          lat;
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_left;
    int          n_acc;
    logic [31:0] last_acc;

    int n_vec;
    int n_err;

    fetch_unit #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(32'h0),
        .FQ_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: record the handshake, cross the rising edge, return on the
    // next falling edge with the cache model advanced and inputs updated.
    task automatic step();
        logic        acc;
        logic [31:0] addr;
        logic        sent;
        #1;
        acc  = req_valid && req_ready;
        addr = req_addr;
        sent = resp_valid;
        @(negedge clk);
        resp_valid     = 1'b0;
        redirect_valid = 1'b0;
        if (sent) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = addr;
            wait_left = lat;
            n_acc++;
            last_acc  = addr;
        end
        if (pend) begin
            wait_left--;
            if (wait_left == 0) begin
                resp_valid = 1'b1;
                resp_data  = pend_addr ^ KEY;
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        pend           = 1'b0;
        lat            = 1;
        step();
        step();
        rst   = 1'b0;
        n_acc = 0;
        #1;
    endtask

    // Step until the DUT presents a request for addr, with a cycle budget.
    task automatic run_to_issue(input string tag, input logic [31:0] addr);
        int n;
        n = 0;
        while (!(req_valid && req_addr == addr) && n < 60) begin
            step();
            n++;
        end
        check(tag, {31'b0, req_valid && (req_addr == addr)}, 32'd1);
    endtask

    initial begin
        int low;
        int bad;
        int n;
        logic [31:0] base;
        n_vec = 0;
        n_err = 0;
        inst_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        // ---- Reset state and streaming with single-cycle hits ----
        rst = 1'b1;
        req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        resp_valid = 1'b0; resp_data = '0; pend = 1'b0; lat = 1;
        step();
        step();
        check("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t1_req_valid", {31'b0, req_valid}, 32'd1);
            check("t1_req_addr", req_addr, 32'(k * 4));
            step();
            check("t1_wait_no_req", {31'b0, req_valid}, 32'd0);
            check("t1_no_early_inst", {31'b0, inst_valid}, 32'd0);
            step();
            check("t1_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("t1_inst_pc", inst_pc, 32'(k * 4));
            check("t1_inst_data", inst_data, 32'(k * 4) ^ KEY);
        end
`ifdef FETCH_PERF_EN
        check("t1_perf_fetched", perf_fetched, 32'd4);
`endif

        // ---- Backpressure: exactly two requests, then stall until a pop ----
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check("t2_req_count", 32'(n_acc), 32'd2);
        check("t2_req_held_low", {31'b0, req_valid}, 32'd0);
        check("t2_head_pc", inst_pc, 32'h0);
        check("t2_head_data", inst_data, KEY);
        inst_ready = 1'b1;
        step();
        check("t2_second_pc", inst_pc, 32'h4);
        check("t2_resume_valid", {31'b0, req_valid}, 32'd1);
        check("t2_resume_addr", req_addr, 32'h8);
        step();
        check("t2_drained", {31'b0, inst_valid}, 32'd0);
        check("t2_last_accept", last_acc, 32'h8);
        step();
        check("t2_pc8", inst_pc, 32'h8);

        // ---- Miss: ten-cycle response for 0x10, queue order kept ----
        inst_ready = 1'b1;
        do_reset();
        run_to_issue("t3_reach_0x10", 32'h10);
        check("t3_head_before", inst_pc, 32'hC);
        inst_ready = 1'b0;
        lat = 10;
`ifdef FETCH_PERF_EN
        base = perf_stall;
`else
        base = '0;
`endif
        step();
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (!req_valid) low++;
            if (i < 9) step();
        end
        check("t3_req_low_cycles", 32'(low), 32'd10);
        step();
`ifdef FETCH_PERF_EN
        check("t3_perf_stall", perf_stall - base, 32'd10);
`endif
        check("t3_head_still_c", inst_pc, 32'hC);
        inst_ready = 1'b1;
        lat = 1;
        step();
        check("t3_next_pc", inst_pc, 32'h10);
        check("t3_next_data", inst_data, 32'hA5A5_A5B5);

        // ---- Redirect to 0x103 while waiting on 0x20 ----
        inst_ready = 1'b1;
        do_reset();
        run_to_issue("t4_reach_0x20", 32'h20);
        inst_ready = 1'b0;
        lat = 5;
        step();
        step();
        check("t4_waiting", {31'b0, req_valid}, 32'd0);
        check("t4_queue_busy", {31'b0, inst_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        step();
        lat = 1;
        check("t4_flushed", {31'b0, inst_valid}, 32'd0);
        check("t4_still_wait", {31'b0, req_valid}, 32'd0);
        bad = 0;
        n = 0;
        while (!req_valid && n < 20) begin
            if (inst_valid) bad++;
            step();
            n++;
        end
        check("t4_reissue", {31'b0, req_valid}, 32'd1);
        check("t4_target_addr", req_addr, 32'h100);
        check("t4_stale_dropped", 32'(bad) + {31'b0, inst_valid}, 32'd0);
        inst_ready = 1'b1;
        step();
        step();
        check("t4_target_pc", inst_pc, 32'h100);
        check("t4_target_data", inst_data, 32'hA5A5_A4A5);

        // ---- Redirect coinciding with resp_valid and a pop ----
        inst_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        check("t5_pre_valid", {31'b0, inst_valid}, 32'd1);
        check("t5_pre_wait", {31'b0, req_valid}, 32'd0);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("t5_empty", {31'b0, inst_valid}, 32'd0);
        check("t5_req_valid", {31'b0, req_valid}, 32'd1);
        check("t5_req_addr", req_addr, 32'h40);
        step();
        step();
        check("t5_pc", inst_pc, 32'h40);
        check("t5_data", inst_data, 32'hA5A5_A5E5);

        // ---- PC wrap at the top of the address space ----
        inst_ready = 1'b1;
        do_reset();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        req_ready = 1'b1;
        check("t6_top_valid", {31'b0, req_valid}, 32'd1);
        check("t6_top_addr", req_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("t6_top_pc", inst_pc, 32'hFFFF_FFFC);
        check("t6_top_data", inst_data, 32'h5A5A_5A59);
        check("t6_wrap_addr", req_addr, 32'h0);
        step();
        step();
        check("t6_wrap_pc", inst_pc, 32'h0);

        // ---- Reset while waiting: late response must be ignored ----
        inst_ready = 1'b1;
        do_reset();
        lat = 3;
        step();
        check("t7_waiting", {31'b0, req_valid}, 32'd0);
        rst = 1'b1;
        req_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("t7_reissue_valid", {31'b0, req_valid}, 32'd1);
        check("t7_reissue_addr", req_addr, 32'h0);
        step();
        step();
        check("t7_late_ignored", {31'b0, inst_valid}, 32'd0);
        req_ready = 1'b1;
        lat = 1;
        step();
        step();
        check("t7_fresh_valid", {31'b0, inst_valid}, 32'd1);
        check("t7_fresh_pc", inst_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
